// File: rtl/mem_stage_if.sv
// Handshake bundle between the EX/MEM register and the memory stage.
// Addr_Err exists only when MEM_ADDR_CHECK_EN is defined.
interface mem_stage_if;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] ALU_Result;
   logic [31:0] Val_Rm;
   logic [31:0] Mem_Result;
   logic        Freeze;
   logic        Done;
`ifdef MEM_ADDR_CHECK_EN
   logic        Addr_Err;

   modport master (
      output MEM_R_EN, MEM_W_EN, ALU_Result, Val_Rm,
      input  Mem_Result, Freeze, Done, Addr_Err
   );
   modport slave (
      input  MEM_R_EN, MEM_W_EN, ALU_Result, Val_Rm,
      output Mem_Result, Freeze, Done, Addr_Err
   );
`else
   modport master (
      output MEM_R_EN, MEM_W_EN, ALU_Result, Val_Rm,
      input  Mem_Result, Freeze, Done
   );
   modport slave (
      input  MEM_R_EN, MEM_W_EN, ALU_Result, Val_Rm,
      output Mem_Result, Freeze, Done
   );
`endif
endinterface

// File: rtl/mem_stage.sv
// Memory stage: word data memory behind a fixed wait-state controller.
// Define MEM_ADDR_CHECK_EN to drop out-of-range accesses and flag Addr_Err.
module mem_stage #(
   parameter int WORDS       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input logic        CLK,
   input logic        RST,
   mem_stage_if.slave bus
);
   localparam int AW = $clog2(WORDS);
   localparam int CW = $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            freeze_c, commit;
   logic            req, same, accept, oor;
   logic [31:0]     off;
   logic [AW-1:0]   idx, lat_idx;
   logic [31:0]     lat_addr, lat_data;
   logic            lat_we, lat_err, held;
   logic [31:0]     mem_result;
   logic            done_q, err_q;
   logic [31:0]     mem [WORDS];

   assign req = bus.MEM_R_EN | bus.MEM_W_EN;
   assign off = bus.ALU_Result - 32'(BASE_ADDR);
   assign idx = AW'(off >> 2);

`ifdef MEM_ADDR_CHECK_EN
   assign oor = (bus.ALU_Result < 32'(BASE_ADDR)) ||
                ((off >> 2) >= 32'(WORDS));
`else
   assign oor = 1'b0;
`endif

   // A request still held after its DONE is the same instruction.
   assign same = (bus.ALU_Result == lat_addr) &&
                 (bus.MEM_W_EN == lat_we) &&
                 (!bus.MEM_W_EN || bus.Val_Rm == lat_data);
   assign accept = req && !(held && same);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      freeze_c = 1'b0;
      commit   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               freeze_c = 1'b1;
               state_n  = BUSY;
               cnt_n    = CW'(1);
            end
         end
         BUSY: begin
            freeze_c = 1'b1;
            if (cnt < CW'(WAIT_CYCLES)) begin
               cnt_n = cnt + CW'(1);
            end else begin
               commit  = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= IDLE;
         cnt        <= '0;
         mem_result <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         held       <= 1'b0;
         lat_idx    <= '0;
         lat_addr   <= '0;
         lat_data   <= '0;
         lat_we     <= 1'b0;
         lat_err    <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         done_q <= commit;
         err_q  <= commit & lat_err;
         if (state == IDLE && accept) begin
            lat_idx  <= idx;
            lat_addr <= bus.ALU_Result;
            lat_data <= bus.Val_Rm;
            lat_we   <= bus.MEM_W_EN;
            lat_err  <= oor;
         end
         if (commit) begin
            held <= 1'b1;
         end else if (state == IDLE && !(req && same)) begin
            held <= 1'b0;
         end
         if (commit && !lat_we) begin
            mem_result <= lat_err ? '0 : mem[lat_idx];
         end
      end
   end

   // Memory array is deliberately left out of reset.
   always_ff @(posedge CLK) begin
      if (RST && commit && lat_we && !lat_err) begin
         mem[lat_idx] <= lat_data;
      end
   end

   assign bus.Mem_Result = mem_result;
   assign bus.Done       = done_q;
   assign bus.Freeze     = RST & freeze_c;
`ifdef MEM_ADDR_CHECK_EN
   assign bus.Addr_Err   = err_q;
`else
   wire unused_err = err_q;
`endif

endmodule
